// File: rtl/gups_pkg.sv
// Shared constants and state encoding for the GUPS address source.
// Holds the LFSR feedback taps, the lock-up-free default and the FSM states.
package gups_pkg;

  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_DEFAULT = 64'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } gups_state_t;

endpackage

// File: rtl/gups_lfsr64.sv
// 64-bit Galois LFSR (right shift, taps 64,63,61,60) with seed load.
// Ports: clk, rst, load, step, seed -> state, next, seed_fix.
import gups_pkg::*;

module gups_lfsr64 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state,
  output logic [W-1:0] next,
  output logic [W-1:0] seed_fix
);

  // An all-zero state would never leave zero.
  assign seed_fix = (seed == '0) ? W'(LFSR_DEFAULT) : seed;

  assign next = state[0] ? ((state >> 1) ^ W'(LFSR_TAPS))
                         : (state >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W'(LFSR_DEFAULT);
    end else if (load) begin
      state <= seed_fix;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/gups_addr_gen.sv
// GUPS random table-address source: seeded LFSR masked by range, valid/ready out.
// Ports: clk, rst, start, seed0..3, range, num_updates -> addr_out,
//        addr_valid (addr_ready in), busy, done, gen_count.
// Build option GUPS_ADDR_ALIGN_EN: emit byte addresses (index << 3).
import gups_pkg::*;

module gups_addr_gen #(
  parameter int ADDR_W = 64,
  parameter int SEED_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEED_W-1:0] seed0,
  input  logic [SEED_W-1:0] seed1,
  input  logic [SEED_W-1:0] seed2,
  input  logic [SEED_W-1:0] seed3,
  input  logic [ADDR_W-1:0] range,
  input  logic [CNT_W-1:0]  num_updates,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  gen_count
);

  gups_state_t       state;
  logic [ADDR_W-1:0] range_q;
  logic [CNT_W-1:0]  num_q;
  logic [ADDR_W-1:0] lfsr_q;
  logic [ADDR_W-1:0] lfsr_next;
  logic [ADDR_W-1:0] seed_fix;
  logic [ADDR_W-1:0] seed_all;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              lfsr_load;
  logic              lfsr_step;

  assign seed_all  = {seed3, seed2, seed1, seed0};
  assign accept    = (state == RUN) && addr_valid && addr_ready;
  assign lfsr_load = (state == LOAD);
  assign lfsr_step = accept;
  assign cnt_inc   = gen_count + CNT_W'(1);

  gups_lfsr64 #(
    .W(ADDR_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .seed    (seed_all),
    .state   (lfsr_q),
    .next    (lfsr_next),
    .seed_fix(seed_fix)
  );

  function automatic logic [ADDR_W-1:0] mk_addr(
    input logic [ADDR_W-1:0] v,
    input logic [ADDR_W-1:0] r
  );
`ifdef GUPS_ADDR_ALIGN_EN
    return (v & r) << 3;
`else
    return v & r;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gen_count  <= '0;
      range_q    <= '0;
      num_q      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        LOAD: begin
          range_q   <= range;
          num_q     <= num_updates;
          gen_count <= '0;
          if (num_updates == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= RUN;
            addr_valid <= 1'b1;
            // First address is the (substituted) seed itself.
            addr_out   <= mk_addr(seed_fix, range);
          end
        end
        RUN: begin
          if (accept) begin
            gen_count <= cnt_inc;
            if (cnt_inc == num_q) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              addr_out <= mk_addr(lfsr_next, range_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gups_addr_gen.sv
// Randomized self-checking bench for gups_addr_gen against a sequence model.
// Ports exercised: all; GUPS_ADDR_ALIGN_EN selects the byte-address model.
module tb_gups_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed0, seed1, seed2, seed3;
  logic [63:0] range;
  logic [31:0] num_updates;
  logic [63:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        busy;
  logic        done;
  logic [31:0] gen_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gups_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed0      (seed0),
    .seed1      (seed1),
    .seed2      (seed2),
    .seed3      (seed3),
    .range      (range),
    .num_updates(num_updates),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: Galois polynomial x^64+x^63+x^61+x^60+1, shifting right.
  function automatic logic [63:0] ref_step(input logic [63:0] v);
    logic [63:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 64'hD800_0000_0000_0000;
    return r;
  endfunction

  function automatic logic [63:0] ref_addr(input logic [63:0] v,
                                           input logic [63:0] r);
`ifdef GUPS_ADDR_ALIGN_EN
    return (v & r) << 3;
`else
    return v & r;
`endif
  endfunction

  // One complete run. hold: cycles with ready forced low at the start.
  // abort: accept count at which reset is pulsed (-1 = never).
  task automatic run(input logic [63:0] sd, input logic [63:0] rg,
                     input logic [31:0] n, input int pct, input int hold,
                     input int abort);
    logic [63:0] lf;
    logic [63:0] lim;
    logic [63:0] exp_a;
    int unsigned acc;
    int          cyc;
    logic        rdy;
    lf  = (sd == 64'd0) ? 64'd1 : sd;
    lim = ref_addr(64'hFFFF_FFFF_FFFF_FFFF, rg);
    acc = 0;
    cyc = 0;
    @(negedge clk);
    {seed3, seed2, seed1, seed0} = sd;
    range       = rg;
    num_updates = n;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the run must use the values captured at LOAD.
    check("load_busy", 64'(busy), 64'd1);
    check("load_valid", 64'(addr_valid), 64'd0);
    @(negedge clk);
    {seed3, seed2, seed1, seed0} = 64'($urandom);
    range       = 64'h3;
    num_updates = 32'd1;
    check("first_valid", 64'(addr_valid), 64'(n != 0));
    if (n == 0) begin
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_cnt", 64'(gen_count), 64'd0);
      return;
    end
    while (acc < n && cyc < 40000) begin
      exp_a = ref_addr(lf, rg);
      check("valid", 64'(addr_valid), 64'd1);
      check("addr", addr_out, exp_a);
      check("range", 64'(addr_out <= lim), 64'd1);
      check("count", 64'(gen_count), 64'(acc));
      if (abort >= 0 && acc == abort) begin
        rst = 1'b1;
        ready_off();
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 64'(addr_valid), 64'd0);
        check("rst_cnt", 64'(gen_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        return;
      end
      rdy = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      addr_ready = rdy;
      start = ($urandom_range(7) == 0);
      @(posedge clk);
      if (rdy) begin
        lf = ref_step(lf);
        acc++;
      end
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    addr_ready = 1'b0;
    check("accepts", 64'(acc), 64'(n));
    check("end_valid", 64'(addr_valid), 64'd0);
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_cnt", 64'(gen_count), 64'(n));
    @(negedge clk);
    check("done_hold", 64'(done), 64'd1);
  endtask

  task automatic ready_off();
    addr_ready = 1'b0;
    start      = 1'b0;
  endtask

  logic [63:0] s;

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    addr_ready  = 1'b0;
    {seed3, seed2, seed1, seed0} = 64'd0;
    range       = 64'd0;
    num_updates = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_addr", addr_out, 64'd0);
    check("rst_valid0", 64'(addr_valid), 64'd0);
    check("rst_busy0", 64'(busy), 64'd0);
    check("rst_done0", 64'(done), 64'd0);
    check("rst_cnt0", 64'(gen_count), 64'd0);
    rst = 1'b0;

    run(64'd0, 64'h1fff, 32'd3, 100, 0, -1);
    run(64'd1, 64'h1fff, 32'd4, 100, 5, -1);
    run(64'd1, 64'h1fff, 32'd0, 100, 0, -1);
    s = {32'($urandom), 32'($urandom)};
    run(s, 64'h1fff, 32'd10000, 50, 0, -1);
    s = {32'($urandom), 32'($urandom)};
    run(s, 64'h1fff, 32'd20, 100, 0, 5);
    run(s, 64'h1fff, 32'd20, 100, 0, -1);
    for (int i = 0; i < 4; i++) begin
      s = {32'($urandom), 32'($urandom)};
      run(s, 64'(32'($urandom)), 32'($urandom_range(60, 1)),
          int'($urandom_range(90, 20)), 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
